tlc_fsm_param: RTL and testbench
================================

Name: tlc_fsm_param

Overview:
Parametrised traffic-light controller for a main/side intersection with a pedestrian walk phase. It generalises the earlier controller by integrating the interval timer, adding runtime-programmable base/extend/yellow durations and a flashing fault mode, and exposing state and remaining time for debug. It sits between the input synchronisers (sensor, walk, prog) and the LED drivers. No external timer module is required.

Parameters:
TICK_DIV, 100000000, clk cycles per one-second tick (≥2).
TIME_W, 4, width of interval registers and countdown, in seconds.
TBASE_DEF, 6, reset value of the base-green interval.
TEXT_DEF, 3, reset value of the extend/walk interval.
TYEL_DEF, 2, reset value of the yellow interval.

Ports:
clk  in  1  system clock.
reset_sync  in  1  synchronous active-high reset.
sensor_sync  in  1  side-road vehicle present (synchronised, level).
walk_req  in  1  pedestrian request (synchronised, pulse or level).
prog_sync  in  1  one-cycle strobe: write prog_val into the interval register chosen by prog_sel.
prog_sel  in  2  0 = base, 1 = extend, 2 = yellow, 3 = ignored (no write, no restart).
prog_val  in  TIME_W  new interval in seconds.
flash_en  in  1  level: enter the flashing fault mode.
leds  out  7  {mainG, mainY, mainR, sideG, sideY, sideR, walk}, registered.
state_o  out  3  current state encoding.
remaining  out  TIME_W  seconds left in the current state.
tick_o  out  1  one-cycle pulse for each one-second tick.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Priority each cycle: reset_sync > prog_sync (sel≠3) > flash_en > normal sequencing.
- Reset values:
  - state MG_BASE (0), leds 1000010, remaining = TBASE_DEF, tick_o 0.
  - Divider = 0, walk latch = 0.
  - Interval registers = their *_DEF values.
- States and LED patterns:
  - MG_BASE (0): 1000010. MG_EXT (1): 1000010. MY (2): 0100010.
  - WALK (3): 0010011. SG_BASE (4): 0011000. SG_EXT (5): 0011000.
  - SY (6): 0010100. FLASH (7): see below.
- Durations:
  - BASE states use tbase. EXT states and WALK use text. Yellow states use tyel.
  - On state entry, the divider clears and remaining loads the state's interval.
  - tick_o pulses when the divider reaches TICK_DIV-1; the divider then wraps to 0.
  - On a tick with remaining > 1, remaining decrements.
  - On a tick with remaining == 1, the state transitions. Each state therefore lasts exactly interval × TICK_DIV cycles.
- Transitions, evaluated on the expiring tick:
  - MG_BASE → MG_EXT if sensor_sync == 0, else → MY.
  - MG_EXT → MY.
  - MY → WALK if walk latch == 1, else → SG_BASE.
  - WALK → SG_BASE, and the walk latch clears.
  - SG_BASE → SG_EXT if sensor_sync == 1, else → SY.
  - SG_EXT → SY.
  - SY → MG_BASE.
- Walk latch:
  - Set by walk_req == 1 in any non-FLASH state.
  - Cleared on WALK exit. If walk_req is asserted in the clear cycle, set wins (latch stays 1).
  - Also cleared by reset and by a valid prog strobe.
- Programming:
  - A prog_val of 0 is stored as 1.
  - The write takes effect in the same cycle.
  - The controller then restarts at MG_BASE with remaining loaded from the new tbase, the divider cleared and the walk latch cleared.
  - prog_sel == 3 is fully ignored.
- FLASH mode:
  - While flash_en == 1, the next cycle enters FLASH. The divider keeps running and remaining holds 0.
  - leds alternate 0100010 / 0000000 on each tick, starting with 0100010 on entry.
  - When flash_en falls, the next cycle enters MG_BASE fresh with leds 1000010 and remaining = tbase.
  - The walk latch clears on FLASH entry, and walk_req is ignored in FLASH.
- Sensor and walk inputs are sampled only on the expiring-tick cycle (the latch is set on any cycle). No glitch filtering is done here.
- Countdown width is TIME_W; intervals never exceed 2^TIME_W - 1, so no overflow is possible.

Test Plan:
- TICK_DIV=4, reset, sensor=0, no walk → MG_BASE for 24 cycles, MG_EXT 12, MY 8, SG_BASE 24, SY 8, back to MG_BASE; leds match each state's pattern.
- sensor=1 throughout → MG_BASE→MY directly; SG_BASE→SG_EXT (12 cycles)→SY.
- walk_req pulse during MG_BASE → WALK follows MY with leds 0010011 for 12 cycles, then SG_BASE; latch is 0 afterwards. A second pulse asserted in the WALK-exit cycle keeps the latch at 1.
- prog_sync with sel=0, val=0 mid-SG_EXT → state 0 next cycle, remaining=1, MG_BASE lasts 4 cycles. sel=3 with val=9 → no change to state or timing.
- flash_en high for 20 cycles during MY → state 7, leds toggle every 4 cycles starting 0100010. On release → MG_BASE, remaining=6.
- reset_sync asserted together with prog_sync and flash_en mid-WALK → all outputs take reset values next cycle; intervals return to 6/3/2.

Source files
------------

// File: rtl/tlc_fsm_param.sv
// Traffic-light controller with built-in one-second timer,
// programmable intervals, flashing fault mode and debug outputs.
module tlc_fsm_param #(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned TIME_W    = 4,
    parameter int unsigned TBASE_DEF = 6,
    parameter int unsigned TEXT_DEF  = 3,
    parameter int unsigned TYEL_DEF  = 2
) (
    input  logic              clk,
    input  logic              reset_sync,
    input  logic              sensor_sync,
    input  logic              walk_req,
    input  logic              prog_sync,
    input  logic [1:0]        prog_sel,
    input  logic [TIME_W-1:0] prog_val,
    input  logic              flash_en,
    output logic [6:0]        leds,
    output logic [2:0]        state_o,
    output logic [TIME_W-1:0] remaining,
    output logic              tick_o
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

    localparam logic [6:0] LED_MG  = 7'b1000010;
    localparam logic [6:0] LED_MY  = 7'b0100010;
    localparam logic [6:0] LED_WK  = 7'b0010011;
    localparam logic [6:0] LED_SG  = 7'b0011000;
    localparam logic [6:0] LED_SY  = 7'b0010100;
    localparam logic [6:0] LED_OFF = 7'b0000000;

    typedef enum logic [2:0] {
        MG_BASE = 3'd0,
        MG_EXT  = 3'd1,
        MY      = 3'd2,
        WALK    = 3'd3,
        SG_BASE = 3'd4,
        SG_EXT  = 3'd5,
        SY      = 3'd6,
        FLASH   = 3'd7
    } state_t;

    state_t            state, state_n, seq_next;
    logic [DIV_W-1:0]  div, div_n;
    logic [TIME_W-1:0] rem_n;
    logic [TIME_W-1:0] tbase, tbase_n;
    logic [TIME_W-1:0] text, text_n;
    logic [TIME_W-1:0] tyel, tyel_n;
    logic [TIME_W-1:0] prog_w;
    logic [6:0]        leds_n;
    logic              tick, tick_n;
    logic              latch, latch_n;
    logic              prog_hit;

    function automatic logic [6:0] pattern(input state_t s);
        unique case (s)
            MG_BASE, MG_EXT: pattern = LED_MG;
            MY:              pattern = LED_MY;
            WALK:            pattern = LED_WK;
            SG_BASE, SG_EXT: pattern = LED_SG;
            SY:              pattern = LED_SY;
            FLASH:           pattern = LED_MY;
        endcase
    endfunction

    function automatic logic [TIME_W-1:0] ival(
        input state_t            s,
        input logic [TIME_W-1:0] tb,
        input logic [TIME_W-1:0] te,
        input logic [TIME_W-1:0] ty
    );
        unique case (s)
            MG_BASE, SG_BASE:     ival = tb;
            MG_EXT, SG_EXT, WALK: ival = te;
            MY, SY:               ival = ty;
            FLASH:                ival = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state     <= MG_BASE;
            div       <= '0;
            remaining <= TIME_W'(TBASE_DEF);
            leds      <= LED_MG;
            tick_o    <= 1'b0;
            latch     <= 1'b0;
            tbase     <= TIME_W'(TBASE_DEF);
            text      <= TIME_W'(TEXT_DEF);
            tyel      <= TIME_W'(TYEL_DEF);
        end else begin
            state     <= state_n;
            div       <= div_n;
            remaining <= rem_n;
            leds      <= leds_n;
            tick_o    <= tick_n;
            latch     <= latch_n;
            tbase     <= tbase_n;
            text      <= text_n;
            tyel      <= tyel_n;
        end
    end

    assign state_o = state;

    always_comb begin
        tick     = (div == DIV_LAST);
        prog_hit = prog_sync && (prog_sel != 2'd3);
        prog_w   = (prog_val == '0) ? ONE : prog_val;
        tbase_n  = tbase;
        text_n   = text;
        tyel_n   = tyel;
        state_n  = state;
        div_n    = tick ? '0 : div + DIV_W'(1);
        rem_n    = remaining;
        leds_n   = leds;
        tick_n   = tick;
        latch_n  = latch;

        unique case (state)
            MG_BASE: seq_next = sensor_sync ? MY : MG_EXT;
            MG_EXT:  seq_next = MY;
            MY:      seq_next = latch ? WALK : SG_BASE;
            WALK:    seq_next = SG_BASE;
            SG_BASE: seq_next = sensor_sync ? SG_EXT : SY;
            SG_EXT:  seq_next = SY;
            SY:      seq_next = MG_BASE;
            FLASH:   seq_next = MG_BASE;
        endcase

        if (prog_hit) begin
            case (prog_sel)
                2'd0:    tbase_n = prog_w;
                2'd1:    text_n  = prog_w;
                default: tyel_n  = prog_w;
            endcase
            state_n = MG_BASE;
            div_n   = '0;
            rem_n   = tbase_n;
            leds_n  = LED_MG;
            tick_n  = 1'b0;
            latch_n = 1'b0;
        end else if (flash_en) begin
            state_n = FLASH;
            rem_n   = '0;
            latch_n = 1'b0;
            if (state != FLASH) begin
                div_n  = '0;
                leds_n = LED_MY;
                tick_n = 1'b0;
            end else if (tick) begin
                leds_n = (leds == LED_MY) ? LED_OFF : LED_MY;
            end
        end else if (state == FLASH) begin
            state_n = MG_BASE;
            div_n   = '0;
            rem_n   = tbase;
            leds_n  = LED_MG;
            tick_n  = 1'b0;
        end else begin
            // a request in the WALK-exit cycle must survive the clear
            if (walk_req) begin
                latch_n = 1'b1;
            end else if (tick && remaining == ONE && state == WALK) begin
                latch_n = 1'b0;
            end
            if (tick) begin
                if (remaining > ONE) begin
                    rem_n = remaining - ONE;
                end else begin
                    state_n = seq_next;
                    div_n   = '0;
                    rem_n   = ival(seq_next, tbase, text, tyel);
                    leds_n  = pattern(seq_next);
                end
            end
        end
    end

endmodule

// File: tb/tb_tlc_fsm_param.sv
// Bench for tlc_fsm_param: hand-derived vector table plus a
// cycle-age reference model driven by directed and random stimulus.
module tb_tlc_fsm_param;

    localparam int TD = 4;

    localparam logic [6:0] MG  = 7'b1000010;
    localparam logic [6:0] MYL = 7'b0100010;
    localparam logic [6:0] WK  = 7'b0010011;
    localparam logic [6:0] SG  = 7'b0011000;
    localparam logic [6:0] SYL = 7'b0010100;
    localparam logic [6:0] OFF = 7'b0000000;

    logic       clk = 1'b0;
    logic       reset_sync = 1'b1;
    logic       sensor_sync = 1'b0;
    logic       walk_req = 1'b0;
    logic       prog_sync = 1'b0;
    logic [1:0] prog_sel = 2'd0;
    logic [3:0] prog_val = 4'd0;
    logic       flash_en = 1'b0;
    logic [6:0] leds;
    logic [2:0] state_o;
    logic [3:0] remaining;
    logic       tick_o;

    always #5 clk = ~clk;

    tlc_fsm_param #(
        .TICK_DIV (TD),
        .TIME_W   (4),
        .TBASE_DEF(6),
        .TEXT_DEF (3),
        .TYEL_DEF (2)
    ) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .sensor_sync(sensor_sync),
        .walk_req   (walk_req),
        .prog_sync  (prog_sync),
        .prog_sel   (prog_sel),
        .prog_val   (prog_val),
        .flash_en   (flash_en),
        .leds       (leds),
        .state_o    (state_o),
        .remaining  (remaining),
        .tick_o     (tick_o)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: state number, cycles spent in state, intervals
    int m_iv[3];
    int m_st  = 0;
    int m_age = 0;
    bit m_latch = 0;
    bit m_tick  = 0;

    function automatic int slot(int s);
        case (s)
            0, 4:    return 0;
            2, 6:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [6:0] pat(int s);
        case (s)
            0, 1:    return MG;
            2:       return MYL;
            3:       return WK;
            4, 5:    return SG;
            default: return SYL;
        endcase
    endfunction

    function automatic int succ(int s, bit sen, bit lat);
        case (s)
            0:       return sen ? 2 : 1;
            1:       return 2;
            2:       return lat ? 3 : 4;
            3:       return 4;
            4:       return sen ? 5 : 6;
            5:       return 6;
            default: return 0;
        endcase
    endfunction

    function logic [6:0] m_leds();
        if (m_st == 7)
            return ((m_age / TD) % 2 == 0) ? MYL : OFF;
        return pat(m_st);
    endfunction

    function int m_rem();
        if (m_st == 7) return 0;
        return m_iv[slot(m_st)] - m_age / TD;
    endfunction

    task automatic model(bit r, bit s, bit w, bit p,
                         int sl, int v, bit f);
        if (r) begin
            m_iv = '{6, 3, 2};
            m_st = 0; m_age = 0; m_latch = 0; m_tick = 0;
        end else if (p && sl != 3) begin
            m_iv[sl] = (v == 0) ? 1 : v;
            m_st = 0; m_age = 0; m_latch = 0; m_tick = 0;
        end else if (f) begin
            if (m_st != 7) begin
                m_st = 7; m_age = 0; m_tick = 0;
            end else begin
                m_age++;
                m_tick = (m_age % TD == 0);
            end
            m_latch = 0;
        end else if (m_st == 7) begin
            m_st = 0; m_age = 0; m_tick = 0;
        end else begin
            bit done;
            bit lat;
            done = (m_age + 1 == m_iv[slot(m_st)] * TD);
            lat  = m_latch;
            m_tick = ((m_age + 1) % TD == 0);
            if (done && m_st == 3) m_latch = 0;
            if (w) m_latch = 1;
            if (done) begin
                m_st  = succ(m_st, s, lat);
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic step(bit r, bit s, bit w, bit p,
                        int sl, int v, bit f);
        reset_sync  = r;
        sensor_sync = s;
        walk_req    = w;
        prog_sync   = p;
        prog_sel    = 2'(sl);
        prog_val    = 4'(v);
        flash_en    = f;
        @(posedge clk);
        model(r, s, w, p, sl, v, f);
        #1;
        vectors++;
        if (leds !== m_leds() || state_o !== 3'(m_st) ||
            remaining !== 4'(m_rem()) || tick_o !== m_tick) begin
            errors++;
            $display("FAIL model t=%0t leds %b want %b st %0d want %0d rem %0d want %0d tick %b want %b",
                     $time, leds, m_leds(), state_o, m_st,
                     remaining, m_rem(), tick_o, m_tick);
        end
    endtask

    typedef struct {
        bit         rst, sen, wlk, prg;
        int         sel, val;
        bit         fl;
        int         n;
        logic [2:0] st;
        logic [3:0] rem;
        logic [6:0] led;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit s, bit w, bit p,
                                int sl, int v, bit f, int n,
                                int st, int rem, logic [6:0] led);
        vec_t e;
        e.rst = r; e.sen = s; e.wlk = w; e.prg = p;
        e.sel = sl; e.val = v; e.fl = f; e.n = n;
        e.st = 3'(st); e.rem = 4'(rem); e.led = led;
        tbl.push_back(e);
    endfunction

    int  tcount;
    int  first;
    bit  rs, rw, rp, rf, rr;
    int  rsel, rval;

    initial begin
        // sensor idle: full cycle through MG_EXT and SG_BASE
        add(1,0,0,0,0,0,0, 1, 0,6,MG);
        add(0,0,0,0,0,0,0, 4, 0,5,MG);
        add(0,0,0,0,0,0,0,20, 1,3,MG);
        add(0,0,0,0,0,0,0,12, 2,2,MYL);
        add(0,0,0,0,0,0,0, 8, 4,6,SG);
        add(0,0,0,0,0,0,0,24, 6,2,SYL);
        add(0,0,0,0,0,0,0, 8, 0,6,MG);
        // sensor busy: skip MG_EXT, take SG_EXT
        add(0,1,0,0,0,0,0,24, 2,2,MYL);
        add(0,1,0,0,0,0,0, 8, 4,6,SG);
        add(0,1,0,0,0,0,0,24, 5,3,SG);
        add(0,1,0,0,0,0,0,12, 6,2,SYL);
        add(0,1,0,0,0,0,0, 8, 0,6,MG);
        // walk pulse, then latch is clear next round
        add(0,1,1,0,0,0,0, 1, 0,6,MG);
        add(0,1,0,0,0,0,0,23, 2,2,MYL);
        add(0,1,0,0,0,0,0, 8, 3,3,WK);
        add(0,1,0,0,0,0,0,12, 4,6,SG);
        add(0,0,0,0,0,0,0,24, 6,2,SYL);
        add(0,0,0,0,0,0,0, 8, 0,6,MG);
        add(0,1,0,0,0,0,0,24, 2,2,MYL);
        add(0,1,0,0,0,0,0, 8, 4,6,SG);
        // request in the WALK-exit cycle keeps latch set
        add(0,0,0,0,0,0,0,24, 6,2,SYL);
        add(0,0,0,0,0,0,0, 8, 0,6,MG);
        add(0,1,0,0,0,0,0,24, 2,2,MYL);
        add(0,1,1,0,0,0,0, 1, 2,2,MYL);
        add(0,1,0,0,0,0,0, 7, 3,3,WK);
        add(0,1,0,0,0,0,0,11, 3,1,WK);
        add(0,1,1,0,0,0,0, 1, 4,6,SG);
        add(0,0,0,0,0,0,0,24, 6,2,SYL);
        add(0,0,0,0,0,0,0, 8, 0,6,MG);
        add(0,1,0,0,0,0,0,24, 2,2,MYL);
        add(0,1,0,0,0,0,0, 8, 3,3,WK);
        // programming mid-SG_EXT, zero stored as one, sel 3 ignored
        add(0,1,0,0,0,0,0,12, 4,6,SG);
        add(0,1,0,0,0,0,0,24, 5,3,SG);
        add(0,1,0,0,0,0,0, 5, 5,2,SG);
        add(0,0,0,1,0,0,0, 1, 0,1,MG);
        add(0,0,0,0,0,0,0, 3, 0,1,MG);
        add(0,0,0,0,0,0,0, 1, 1,3,MG);
        add(0,0,0,1,3,9,0, 1, 1,3,MG);
        add(0,0,0,0,0,0,0,11, 2,2,MYL);
        add(0,0,0,1,0,6,0, 1, 0,6,MG);
        // flash for 20 cycles during MY
        add(0,1,0,0,0,0,0,24, 2,2,MYL);
        add(0,0,0,0,0,0,1, 1, 7,0,MYL);
        add(0,0,0,0,0,0,1, 3, 7,0,MYL);
        add(0,0,0,0,0,0,1, 1, 7,0,OFF);
        add(0,0,0,0,0,0,1,15, 7,0,MYL);
        add(0,0,0,0,0,0,0, 1, 0,6,MG);
        // reset beats prog and flash mid-WALK
        add(0,1,1,0,0,0,0, 1, 0,6,MG);
        add(0,1,0,0,0,0,0,23, 2,2,MYL);
        add(0,1,0,0,0,0,0, 8, 3,3,WK);
        add(0,1,0,0,0,0,0, 5, 3,2,WK);
        add(1,0,0,1,1,5,1, 1, 0,6,MG);
        add(0,0,0,0,0,0,0,24, 1,3,MG);
        add(0,0,0,0,0,0,0,12, 2,2,MYL);
        add(0,0,0,0,0,0,0, 8, 4,6,SG);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++)
                step(tbl[i].rst, tbl[i].sen, tbl[i].wlk,
                     tbl[i].prg, tbl[i].sel, tbl[i].val,
                     tbl[i].fl);
            vectors++;
            if (state_o !== tbl[i].st ||
                remaining !== tbl[i].rem ||
                leds !== tbl[i].led) begin
                errors++;
                $display("FAIL table[%0d] st %0d want %0d rem %0d want %0d leds %b want %b",
                         i, state_o, tbl[i].st, remaining,
                         tbl[i].rem, leds, tbl[i].led);
            end
        end

        // tick spacing right after reset
        step(1,0,0,0,0,0,0);
        tcount = 0;
        first  = -1;
        for (int k = 1; k <= 8; k++) begin
            step(0,0,0,0,0,0,0);
            if (tick_o === 1'b1) begin
                tcount++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (tcount != 2 || first != 4) begin
            errors++;
            $display("FAIL tick_spacing count %0d want 2 first %0d want 4",
                     tcount, first);
        end

        // extend interval reprogrammed to 5 s
        step(0,0,0,1,1,5,0);
        for (int k = 0; k < 24 + 19; k++) step(0,0,0,0,0,0,0);
        vectors++;
        if (state_o !== 3'd1 || remaining !== 4'd1) begin
            errors++;
            $display("FAIL ext5_hold st %0d want 1 rem %0d want 1",
                     state_o, remaining);
        end
        step(0,0,0,0,0,0,0);
        vectors++;
        if (state_o !== 3'd2 || remaining !== 4'd2) begin
            errors++;
            $display("FAIL ext5_exit st %0d want 2 rem %0d want 2",
                     state_o, remaining);
        end

        // random stimulus against the model
        step(1,0,0,0,0,0,0);
        rs = 0;
        rf = 0;
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 39) == 0) rs = ~rs;
            rw   = ($urandom_range(0, 15) == 0);
            rp   = ($urandom_range(0, 99) == 0);
            rsel = $urandom_range(0, 3);
            rval = $urandom_range(0, 7);
            if (rf) begin
                if ($urandom_range(0, 29) == 0) rf = 0;
            end else if ($urandom_range(0, 399) == 0) begin
                rf = 1;
            end
            rr = ($urandom_range(0, 1999) == 0);
            step(rr, rs, rw, rp, rsel, rval, rf);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
